// File: rtl/mem_access.sv
// mem_access: memory-access stage of the Pillar pipeline.
// Takes one instruction at a time from execute, performs data-memory loads and
// stores over a req/ack port, and hands ir/pc/alu result/load result to
// write-back together with a one-cycle completion strobe.
// Optional feature: define MEM_TIMEOUT_EN to add an ack watchdog of
// TIMEOUT_CYCLES cycles on the memory request.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] ir_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] rs2_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic [31:0] ir_o,
    output logic [31:0] pc_o,
    output logic [31:0] wd_o,
    output logic [31:0] mem_o,
    output logic        wd_q_readin_o,
    output logic        err_o
);

    // Only load and store opcodes change the flow; R/I types (0110011,
    // 0010011) and anything unrecognised simply pass through to write-back.
    localparam logic [6:0] DECODE_L_TYPE = 7'b0000011;
    localparam logic [6:0] DECODE_S_TYPE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Instruction captured at accept time
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rs2_q, rs2_d;

    // Write-back facing registers
    logic [31:0] ir_out_q, ir_out_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] wd_out_q, wd_out_d;
    logic [31:0] mem_out_q, mem_out_d;
    logic        strobe_q, strobe_d;
    logic        err_q, err_d;

    logic        go_done;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Misalignment: byte accesses never; halfwords need off[0]=0; words
    // (including unknown funct3) need off=0. Store funct3 100/101 are unknown.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic is_load,
                                           input logic [1:0] off);
        case (f3)
            3'b000:  return 1'b0;
            3'b100:  return is_load ? 1'b0 : (off != 2'b00);
            3'b001:  return off[0];
            3'b101:  return is_load ? off[0] : (off != 2'b00);
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  return 4'b0001 << off;
            3'b001:  return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3)
            3'b000:  return {4{rs2[7:0]}};
            3'b001:  return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return rdata;
        endcase
    endfunction

    // Decode of the incoming instruction (used only in IDLE) and of the held one
    logic in_is_ld, in_is_st, in_is_ls, in_mis;
    logic q_is_ld, q_is_st;

    assign in_is_ld = (ir_i[6:0] == DECODE_L_TYPE);
    assign in_is_st = (ir_i[6:0] == DECODE_S_TYPE);
    assign in_is_ls = in_is_ld | in_is_st;
    assign in_mis   = in_is_ls & is_misaligned(ir_i[14:12], in_is_ld, alu_i[1:0]);
    assign q_is_ld  = (ir_q[6:0] == DECODE_L_TYPE);
    assign q_is_st  = (ir_q[6:0] == DECODE_S_TYPE);

    // Memory port: driven from held registers only while requesting, so the
    // fields stay stable for the whole request and read 0 otherwise.
    logic in_req;
    assign in_req       = (state_q == S_REQ);
    assign dmem_req_o   = in_req;
    assign dmem_we_o    = in_req & q_is_st;
    assign dmem_addr_o  = in_req ? {alu_q[31:2], 2'b00} : 32'h0;
    assign dmem_be_o    = in_req ? store_be(ir_q[14:12], alu_q[1:0]) : 4'b0000;
    assign dmem_wdata_o = (in_req & q_is_st) ? store_wdata(ir_q[14:12], rs2_q) : 32'h0;

    assign ir_o          = ir_out_q;
    assign pc_o          = pc_out_q;
    assign wd_o          = wd_out_q;
    assign mem_o         = mem_out_q;
    assign wd_q_readin_o = strobe_q;
    assign err_o         = err_q;

    // Next-state and datapath update for the IDLE/REQ/DONE sequence
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        alu_d     = alu_q;
        rs2_d     = rs2_q;
        ir_out_d  = ir_out_q;
        pc_out_d  = pc_out_q;
        wd_out_d  = wd_out_q;
        mem_out_d = mem_out_q;
        strobe_d  = 1'b0;
        err_d     = err_q;
        go_done   = 1'b0;
        ready_o   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    ir_d  = ir_i;
                    pc_d  = pc_i;
                    alu_d = alu_i;
                    rs2_d = rs2_i;
`ifdef MEM_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    if (in_is_ls && !in_mis) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DONE;
                        go_done = 1'b1;
                        // Misaligned L/S: no request, flag it, clear the load result
                        if (in_is_ls) begin
                            err_d     = 1'b1;
                            mem_out_d = 32'h0;
                        end
                    end
                end
            end
            S_REQ: begin
                if (dmem_ack_i) begin
                    state_d = S_DONE;
                    go_done = 1'b1;
                    if (q_is_ld) begin
                        mem_out_d = load_extract(ir_q[14:12], alu_q[1:0], dmem_rdata_i);
                    end
`ifdef MEM_TIMEOUT_EN
                // An ack arriving in the expiry cycle takes priority (branch above)
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = S_DONE;
                    go_done   = 1'b1;
                    err_d     = 1'b1;
                    mem_out_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entering DONE publishes the instruction to write-back with the strobe
        if (go_done) begin
            strobe_d = 1'b1;
            ir_out_d = ir_d;
            pc_out_d = pc_d;
            wd_out_d = alu_d;
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ir_q      <= 32'h0;
            pc_q      <= 32'h0;
            alu_q     <= 32'h0;
            rs2_q     <= 32'h0;
            ir_out_q  <= 32'h0;
            pc_out_q  <= 32'h0;
            wd_out_q  <= 32'h0;
            mem_out_q <= 32'h0;
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            alu_q     <= alu_d;
            rs2_q     <= rs2_d;
            ir_out_q  <= ir_out_d;
            pc_out_q  <= pc_out_d;
            wd_out_q  <= wd_out_d;
            mem_out_q <= mem_out_d;
            strobe_q  <= strobe_d;
            err_q     <= err_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Watchdog counter for the outstanding request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: randomized instructions and memory latencies
// checked every cycle against a transaction-level model, plus directed cases.
module tb_mem_access;

`ifdef MEM_TIMEOUT_EN
    localparam int TO         = 4;
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam int TO         = 16;
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] ir_i = '0, pc_i = '0, alu_i = '0, rs2_i = '0;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_rdata_i = '0;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] ir_o, pc_o, wd_o, mem_o;
    logic        wd_q_readin_o, err_o;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .ir_i         (ir_i),
        .pc_i         (pc_i),
        .alu_i        (alu_i),
        .rs2_i        (rs2_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_rdata_i (dmem_rdata_i),
        .dmem_ack_i   (dmem_ack_i),
        .ir_o         (ir_o),
        .pc_o         (pc_o),
        .wd_o         (wd_o),
        .mem_o        (mem_o),
        .wd_q_readin_o(wd_q_readin_o),
        .err_o        (err_o)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Expected per-cycle outputs
    logic        e_ready = 1'b1, e_req = 1'b0, e_we = 1'b0, e_store = 1'b0, e_strobe = 1'b0;
    logic [31:0] e_addr = '0, e_wdata = '0;
    logic [3:0]  e_be = '0;
    // Model of write-back facing state
    logic [31:0] m_ir = '0, m_pc = '0, m_wd = '0, m_mem = '0;
    logic        m_err = 1'b0;

    // Observation bookkeeping
    int cyc = 0, acc_cyc = 0, strobe_cyc = 0, req_cycles = 0;
    logic [31:0] last_addr = '0, last_wdata = '0;
    logic [3:0]  last_be = '0;
    logic        last_we = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Spec-level access size in bytes
    function automatic int acc_size(input logic [2:0] f3, input bit is_ld);
        if (f3 == 3'd0 || (is_ld && f3 == 3'd4)) return 1;
        if (f3 == 3'd1 || (is_ld && f3 == 3'd5)) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] f_be(input int sz, input int off);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] f_wdata(input int sz, input logic [31:0] rs2);
        if (sz == 1) return {24'h0, rs2[7:0]} * 32'h01010101;
        if (sz == 2) return {16'h0, rs2[15:0]} * 32'h00010001;
        return rs2;
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] f3, input int sz, input int off,
                                           input logic [31:0] rd);
        longint v, mask;
        if (sz == 4) return rd;
        v = longint'({32'h0, rd}) >> (8 * off);
        mask = (longint'(1) << (8 * sz)) - 1;
        v = v & mask;
        if (f3[2] == 1'b0 && v[8*sz-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] mk_ir(input logic [6:0] opc, input logic [2:0] f3);
        logic [31:0] r;
        r = $urandom;
        r[6:0] = opc;
        r[14:12] = f3;
        return r;
    endfunction

    task automatic set_idle_exp();
        e_ready = 1'b1; e_req = 1'b0; e_strobe = 1'b0; e_we = 1'b0; e_store = 1'b0;
        e_addr = '0; e_be = '0; e_wdata = '0;
    endtask

    task automatic junk_inputs();
        valid_i = 1'($urandom);
        ir_i = $urandom; pc_i = $urandom; alu_i = $urandom; rs2_i = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_idle_exp();
            valid_i = 1'b0;
            dmem_ack_i = 1'($urandom);
            dmem_rdata_i = $urandom;
            @(negedge clk);
        end
        set_idle_exp();
    endtask

    // One instruction from accept to strobe; called at a negedge in IDLE,
    // returns at the negedge of the first IDLE cycle after the strobe.
    task automatic do_instr(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] alu,
                            input logic [31:0] rs2, input int wt, input logic [31:0] rdata);
        logic [2:0] f3;
        int sz, off, c;
        bit is_ld, is_st, mis, timed_out;
        f3 = ir[14:12];
        off = int'(alu[1:0]);
        is_ld = (ir[6:0] == OP_L);
        is_st = (ir[6:0] == OP_S);
        sz = acc_size(f3, is_ld);
        mis = (is_ld || is_st) && ((off % sz) != 0);
        timed_out = 1'b0;
        // cycle 0: accept
        set_idle_exp();
        acc_cyc = cyc;
        valid_i = 1'b1; ir_i = ir; pc_i = pc; alu_i = alu; rs2_i = rs2;
        dmem_ack_i = 1'($urandom);
        dmem_rdata_i = $urandom;
        @(negedge clk);
        if ((is_ld || is_st) && !mis) begin
            c = 0;
            forever begin
                if (TIMEOUT_ON && c == TO) begin
                    timed_out = 1'b1;
                    break;
                end
                e_ready = 1'b0; e_req = 1'b1; e_strobe = 1'b0;
                e_we = is_st; e_store = is_st;
                e_addr = {alu[31:2], 2'b00};
                e_be = f_be(sz, off);
                e_wdata = f_wdata(sz, rs2);
                junk_inputs();
                dmem_ack_i = (c == wt);
                dmem_rdata_i = (c == wt) ? rdata : $urandom;
                @(negedge clk);
                if (c == wt) break;
                c++;
            end
        end
        // strobe cycle
        m_ir = ir; m_pc = pc; m_wd = alu;
        if (mis || timed_out) begin
            m_mem = 32'h0;
            m_err = 1'b1;
        end else if (is_ld) begin
            m_mem = f_load(f3, sz, off, rdata);
        end
        e_ready = 1'b0; e_req = 1'b0; e_strobe = 1'b1; e_we = 1'b0; e_store = 1'b0;
        junk_inputs();
        dmem_ack_i = 1'($urandom);
        dmem_rdata_i = $urandom;
        @(negedge clk);
        valid_i = 1'b0;
        dmem_ack_i = 1'b0;
        set_idle_exp();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: DUT against the model once per cycle, away from the edge
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (wd_q_readin_o) strobe_cyc = cyc;
            if (dmem_req_o) begin
                req_cycles++;
                last_addr = dmem_addr_o; last_be = dmem_be_o;
                last_wdata = dmem_wdata_o; last_we = dmem_we_o;
            end
            if (chk_en) begin
                chk("ready", 32'(ready_o), 32'(e_ready));
                chk("req", 32'(dmem_req_o), 32'(e_req));
                chk("strobe", 32'(wd_q_readin_o), 32'(e_strobe));
                chk("ir_o", ir_o, m_ir);
                chk("pc_o", pc_o, m_pc);
                chk("wd_o", wd_o, m_wd);
                chk("mem_o", mem_o, m_mem);
                chk("err_o", 32'(err_o), 32'(m_err));
                if (e_req) begin
                    chk("addr", dmem_addr_o, e_addr);
                    chk("we", 32'(dmem_we_o), 32'(e_we));
                    if (e_store) begin
                        chk("be", 32'(dmem_be_o), 32'(e_be));
                        chk("wdata", dmem_wdata_o, e_wdata);
                    end
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 32'(dmem_req_o), 32'h0);
        chk({tag, "_we"}, 32'(dmem_we_o), 32'h0);
        chk({tag, "_be"}, 32'(dmem_be_o), 32'h0);
        chk({tag, "_addr"}, dmem_addr_o, 32'h0);
        chk({tag, "_wdata"}, dmem_wdata_o, 32'h0);
        chk({tag, "_ir"}, ir_o, 32'h0);
        chk({tag, "_pc"}, pc_o, 32'h0);
        chk({tag, "_wd"}, wd_o, 32'h0);
        chk({tag, "_mem"}, mem_o, 32'h0);
        chk({tag, "_strobe"}, 32'(wd_q_readin_o), 32'h0);
        chk({tag, "_err"}, 32'(err_o), 32'h0);
        chk({tag, "_ready"}, 32'(ready_o), 32'h1);
    endtask

    task automatic model_reset();
        m_ir = '0; m_pc = '0; m_wd = '0; m_mem = '0; m_err = 1'b0;
        set_idle_exp();
    endtask

    initial begin
        int rq0, hold_n;
        logic [31:0] rs2v;
        // Power-on reset
        #1;
        chk_all_zero("rst0");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
        idle(2);

        // R-type: strobe one cycle after accept, no memory request
        rq0 = req_cycles;
        do_instr(mk_ir(OP_R, 3'd0), 32'h100, 32'h1234, 32'h0, 0, 32'h0);
        chk("r_gap", 32'(strobe_cyc - acc_cyc), 32'd1);
        chk("r_wd", wd_o, 32'h00001234);
        chk("r_noreq", 32'(req_cycles - rq0), 32'd0);

        // LB at 0x103, ack after 3 wait cycles
        do_instr(mk_ir(OP_L, 3'b000), 32'h104, 32'h103, 32'h0, 3, 32'h80FFFFFF);
        chk("lb_mem", mem_o, 32'hFFFFFF80);
        chk("lb_gap", 32'(strobe_cyc - acc_cyc), 32'd5);

        // LBU, same stimulus
        do_instr(mk_ir(OP_L, 3'b100), 32'h108, 32'h103, 32'h0, 3, 32'h80FFFFFF);
        chk("lbu_mem", mem_o, 32'h00000080);

        // Zero-wait load: strobe in cycle 2
        do_instr(mk_ir(OP_L, 3'b010), 32'h10C, 32'h200, 32'h0, 0, 32'hCAFEF00D);
        chk("lw0_gap", 32'(strobe_cyc - acc_cyc), 32'd2);
        chk("lw0_mem", mem_o, 32'hCAFEF00D);

        // SH at 0x102, mem_o must keep the previous load value
        do_instr(mk_ir(OP_S, 3'b001), 32'h110, 32'h102, 32'h0000BEEF, 1, 32'h0);
        chk("sh_addr", last_addr, 32'h00000100);
        chk("sh_be", 32'(last_be), 32'hC);
        chk("sh_wdata", last_wdata, 32'hBEEFBEEF);
        chk("sh_we", 32'(last_we), 32'h1);
        chk("sh_mem_kept", mem_o, 32'hCAFEF00D);

        // Misaligned LW at 0x102
        rq0 = req_cycles;
        do_instr(mk_ir(OP_L, 3'b010), 32'h114, 32'h102, 32'h0, 0, 32'h12345678);
        chk("mis_err", 32'(err_o), 32'h1);
        chk("mis_mem", mem_o, 32'h0);
        chk("mis_gap", 32'(strobe_cyc - acc_cyc), 32'd1);
        chk("mis_noreq", 32'(req_cycles - rq0), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            int k;
            logic [6:0] opc;
            logic [31:0] alu;
            k = $urandom_range(0, 4);
            case (k)
                0: opc = OP_R;
                1: opc = OP_I;
                2: opc = OP_L;
                3: opc = OP_S;
                default: opc = 7'($urandom);
            endcase
            alu = $urandom;
            if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
            do_instr(mk_ir(opc, 3'($urandom)), $urandom, alu, $urandom,
                     $urandom_range(0, 6), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        // Reset in the middle of a pending SW to 0x40
        hold_n = TIMEOUT_ON ? 2 : 100;
        rs2v = $urandom;
        set_idle_exp();
        valid_i = 1'b1; ir_i = mk_ir(OP_S, 3'b010); pc_i = 32'h200; alu_i = 32'h40; rs2_i = rs2v;
        dmem_ack_i = 1'b0;
        @(negedge clk);
        for (int i = 0; i < hold_n; i++) begin
            e_ready = 1'b0; e_req = 1'b1; e_strobe = 1'b0; e_we = 1'b1; e_store = 1'b1;
            e_addr = 32'h40; e_be = 4'hF; e_wdata = rs2v;
            junk_inputs();
            dmem_ack_i = 1'b0;
            @(negedge clk);
        end
        chk("hold_req", 32'(dmem_req_o), 32'h1);
        #3;
        chk_en = 1'b0;
        dmem_ack_i = 1'b1;
        valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rstreq");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
        // The ack still high after release must be ignored
        for (int i = 0; i < 2; i++) begin
            set_idle_exp();
            valid_i = 1'b0;
            dmem_ack_i = 1'b1;
            @(negedge clk);
        end
        dmem_ack_i = 1'b0;
        chk("post_rst_ready", 32'(ready_o), 32'h1);

        if (TIMEOUT_ON) begin
            // Ack never comes: request drops after TO cycles
            rq0 = req_cycles;
            do_instr(mk_ir(OP_S, 3'b010), 32'h300, 32'h40, 32'h55AA55AA, TO + 3, 32'h0);
            chk("to_req_cycles", 32'(req_cycles - rq0), 32'd4);
            chk("to_err", 32'(err_o), 32'h1);
            chk("to_mem", mem_o, 32'h0);
        end

        for (int i = 0; i < 30; i++) begin
            logic [31:0] alu;
            alu = $urandom;
            alu[1:0] = 2'($urandom_range(0, 1) * 2);
            do_instr(mk_ir(($urandom_range(0, 1) == 1) ? OP_L : OP_S, 3'($urandom)),
                     $urandom, alu, $urandom, $urandom_range(0, 5), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the Pillar pipeline, directly upstream of the write-back stage. It accepts one instruction at a time from execute and performs data-memory loads and stores over a req/ack port. It presents the load result (`mem_o`) and the ALU result (`wd_o`) to write-back. It fires the one-cycle `wd_q_readin_o` strobe that write-back uses to latch its data.

## Interface
- `TIMEOUT_CYCLES`, 16: watchdog limit on `dmem_ack_i` wait; used only with `MEM_TIMEOUT_EN`.
- `clk`  in  1  clock. Single clock domain.
- `reset`  in  1  reset, asynchronous and active-low.
- `valid_i`  in  1  execute presents an instruction.
- `ready_o`  out  1  stage can accept.
- `ir_i`  in  32  instruction word.
- `pc_i`  in  32  instruction PC.
- `alu_i`  in  32  ALU result: effective byte address for L/S, writeback data for R/I.
- `rs2_i`  in  32  store data.
- `dmem_req_o`  out  1  memory request.
- `dmem_we_o`  out  1  1 = store.
- `dmem_addr_o`  out  32  word-aligned address, `{alu[31:2],2'b00}`.
- `dmem_wdata_o`  out  32  lane-shifted store data.
- `dmem_be_o`  out  4  byte enables.
- `dmem_rdata_i`  in  32  read data, valid with ack.
- `dmem_ack_i`  in  1  request complete.
- `ir_o`, `pc_o`, `wd_o`, `mem_o`  out  32 each  registered outputs to write-back.
- `wd_q_readin_o`  out  1  one-cycle completion strobe.
- `err_o`  out  1  sticky error: misaligned access or timeout.

## Operation
- Opcodes come from `opcode.v`: `DECODE_R_TYPE` 0110011, `DECODE_I_TYPE` 0010011, `DECODE_L_TYPE` 0000011, `DECODE_S_TYPE` 0100011.
- FSM states are IDLE, REQ, DONE.
- **IDLE**
  - `ready_o`=1.
  - On `valid_i`, register `ir`, `pc`, `alu` and `rs2`.
  - L or S type and aligned: go to REQ.
  - Anything else: go to DONE.
- **REQ**
  - `dmem_req_o`=1.
  - `dmem_addr_o`, `dmem_we_o`, `dmem_be_o` and `dmem_wdata_o` are held stable until ack.
  - On `dmem_ack_i`: for a load, capture the extended read data into `mem_o`; then go to DONE.
- **DONE**
  - `wd_q_readin_o`=1 for exactly one cycle.
  - `ir_o`/`pc_o`/`wd_o` reflect the instruction.
  - Go to IDLE.
- `wd_o` = registered `alu`. For non-loads, `mem_o` keeps its previous value.
- Store lanes, using funct3 = `ir[14:12]` and off = `alu[1:0]`:
  - SB: be = 0001<<off; wdata = `{4{rs2[7:0]}}`.
  - SH: be = 0011<<off; wdata = `{2{rs2[15:0]}}`.
  - SW: be = 1111; wdata = `rs2`.
- Load extraction: select the byte or halfword at off from rdata.
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW takes the full word.
- Misaligned access (LH/LHU/SH with off[0]=1, or LW/SW with off≠0):
  - No memory request is issued.
  - `err_o` is set.
  - `mem_o` is forced to 0.
  - Flow proceeds to DONE, so write-back still advances.
- Unknown funct3 on L/S is treated as a word access.

## Timing
- Reset (asynchronous):
  - State → IDLE.
  - `dmem_req_o`, `dmem_we_o`, `dmem_be_o`, `dmem_addr_o`, `dmem_wdata_o` → 0.
  - `ir_o`, `pc_o`, `wd_o`, `mem_o` → 0.
  - `wd_q_readin_o` → 0, `err_o` → 0.
  - `ready_o` → 1.
  - Reset during REQ drops `dmem_req_o` immediately; the pending ack is ignored.
- R/I type: accept in cycle 0, strobe in cycle 1. Throughput is one instruction per 2 cycles.
- L/S type: accept in cycle 0, `dmem_req_o` rises in cycle 1.
  - An ack sampled in cycle k puts the strobe in cycle k+1.
  - Zero-wait memory (ack in cycle 1) gives the strobe in cycle 2.
- `dmem_ack_i` outside REQ is ignored.
- `ready_o`=0 in REQ and DONE. `valid_i` is not consumed there.
- `ir_o`/`wd_o`/`mem_o` are stable from the strobe cycle until the next strobe.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter runs in REQ.
  - If `TIMEOUT_CYCLES` cycles elapse without ack: drop the request, set `err_o`, force `mem_o` to 0, go to DONE.
  - An ack in the same cycle as expiry wins.
- Without the macro, REQ waits indefinitely and no counter is built.

## Test plan
- Reset low mid-REQ (SW to 0x40 pending) → `dmem_req_o`=0 that cycle; all outputs 0; `ready_o`=1 after reset release.
- R-type, `alu_i`=0x1234 → `wd_q_readin_o` pulses exactly 1 cycle after accept; `wd_o`=0x1234; no `dmem_req_o`.
- LB at 0x103, rdata=0x80FFFFFF, ack after 3 wait cycles → `mem_o`=0xFFFFFF80; strobe in the cycle after ack.
  - LBU with the same stimulus → `mem_o`=0x00000080.
- SH at 0x102 with `rs2_i`=0xBEEF → `dmem_addr_o`=0x100, `dmem_be_o`=1100, `dmem_wdata_o`=0xBEEFBEEF, `dmem_we_o`=1.
- LW at 0x102 → no request; `err_o`=1; `mem_o`=0; strobe 1 cycle after accept.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, ack never arrives → request drops after 4 cycles; `err_o`=1; strobe fires.
  - Without the macro, the request is still held at 100 cycles.
